ram_clearable: RTL and testbench

RAM_CLEARABLE -- requirements
Module: ram_clearable

---
 rtl/ram_clearable_if.sv | 41 ++++
 rtl/ram_clearable.sv | 96 +++++++++
 tb/tb_ram_clearable.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_clearable_if.sv
// rtl/ram_clearable_if.sv - request/response bundle for the clearable RAM
//
// Purpose: groups the access request signals (write data, write enable,
// address, read request, clear request) and the response signals (read
// data, read-data valid, clear-in-progress) of ram_clearable.
//
// Signals:
//   value      WIDTH      write data
//   load       1          write enable
//   address    ADDR_BITS  word address for read and write
//   read       1          read request
//   clear      1          request a hardware clear of the whole array
//   out        WIDTH      registered read data
//   out_valid  1          out carries data from the read accepted last edge
//   busy       1          clear sequence active, requests are ignored
//
// Modports: master drives requests and observes responses; slave is the RAM.

interface ram_clearable_if #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 9
);
   logic [WIDTH-1:0]     value;
   logic                 load;
   logic [ADDR_BITS-1:0] address;
   logic                 read;
   logic                 clear;
   logic [WIDTH-1:0]     out;
   logic                 out_valid;
   logic                 busy;

   modport master (
      output value, load, address, read, clear,
      input  out, out_valid, busy
   );

   modport slave (
      input  value, load, address, read, clear,
      output out, out_valid, busy
   );
endinterface

// File: rtl/ram_clearable.sv
// rtl/ram_clearable.sv - single-port RAM with a hardware clear sequence
//
// Purpose: DEPTH x WIDTH word memory with one-cycle registered reads
// (read-first on same-address read/write) and a sequential clear that
// zeroes every word, one per clock, after reset or on request.
//
// Ports:
//   clk    1              single clock, all state changes on the rising edge
//   reset  1              synchronous active-high reset; starts a full clear
//   bus    slave modport  value/load/address/read/clear in,
//                         out/out_valid/busy out
//
// Parameters:
//   WIDTH      data word width in bits
//   ADDR_BITS  address width; DEPTH = 2**ADDR_BITS words

module ram_clearable #(
   parameter int WIDTH     = 16,
   parameter int ADDR_BITS = 9
) (
   input  logic             clk,
   input  logic             reset,
   ram_clearable_if.slave   bus
);

   localparam int DEPTH = 1 << ADDR_BITS;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

   logic [0:0]           state;
   logic [ADDR_BITS-1:0] clr_ptr;
   logic [WIDTH-1:0]     out_q;
   logic                 out_valid_q;

   // No reset on the array itself so it can map onto a plain RAM macro;
   // its contents are defined by the clear sequence that reset launches.
   logic [WIDTH-1:0]     mem [0:DEPTH-1];

   // A clear request in IDLE takes priority over a load on the same edge.
   logic                 do_clear_req;
   logic                 do_load;
   logic                 do_read;

   always_comb begin
      do_clear_req = (state == IDLE) && bus.clear;
      do_load      = (state == IDLE) && !bus.clear && bus.load;
      do_read      = (state == IDLE) && !bus.clear && bus.read;
   end

   // Control state, clear pointer and registered read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         // Reset parks the pointer at 0; nothing is written until release.
         state       <= CLEAR;
         clr_ptr     <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (state == CLEAR) begin
         out_valid_q <= 1'b0;
         // Pointer wraps to 0 naturally on the final step.
         clr_ptr     <= clr_ptr + 1'b1;
         if (clr_ptr == LAST_ADDR) begin
            state <= IDLE;
         end
      end else if (do_clear_req) begin
         state       <= CLEAR;
         clr_ptr     <= '0;
         out_valid_q <= 1'b0;
      end else if (do_read) begin
         // Non-blocking read of mem sees the pre-edge word: read-first.
         out_q       <= mem[bus.address];
         out_valid_q <= 1'b1;
      end else begin
         out_valid_q <= 1'b0;
      end
   end

   // Single write port shared between the clear sequence and user loads.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
         end else if (do_load) begin
            mem[bus.address] <= bus.value;
         end
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state == CLEAR);

endmodule

// File: tb/tb_ram_clearable.sv
// tb/tb_ram_clearable.sv - scoreboard bench for ram_clearable

module tb_ram_clearable;

   localparam int W     = 16;
   localparam int AB    = 9;
   localparam int DEPTH = 1 << AB;

   localparam int SW     = 8;
   localparam int SAB    = 4;
   localparam int SDEPTH = 1 << SAB;

   logic clk = 1'b0;
   logic reset;
   logic sreset;

   always #5 clk = ~clk;

   ram_clearable_if #(.WIDTH(W), .ADDR_BITS(AB)) bus ();
   ram_clearable #(.WIDTH(W), .ADDR_BITS(AB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   ram_clearable_if #(.WIDTH(SW), .ADDR_BITS(SAB)) sbus ();
   ram_clearable #(.WIDTH(SW), .ADDR_BITS(SAB)) sdut (
      .clk   (clk),
      .reset (sreset),
      .bus   (sbus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         b;
   } exp_t;

   exp_t          q[$];
   logic [SW-1:0] q2[$];

   // Reference model: a plain array plus a count of remaining clear edges.
   logic [W-1:0] mm [DEPTH];
   int           busy_left;
   logic [W-1:0] eo;
   logic         ev;

   task automatic model_zero();
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
   endtask

   task automatic cyc(input logic r, input logic ld, input logic rd,
                      input logic clr, input logic [AB-1:0] a,
                      input logic [W-1:0] v);
      exp_t e;
      @(negedge clk);
      reset       = r;
      bus.load    = ld;
      bus.read    = rd;
      bus.clear   = clr;
      bus.address = a;
      bus.value   = v;
      if (r) begin
         // Whole array ends up zero and is unreachable until then.
         busy_left = DEPTH;
         eo = '0;
         ev = 1'b0;
         model_zero();
      end else if (busy_left > 0) begin
         busy_left--;
         ev = 1'b0;
      end else if (clr) begin
         busy_left = DEPTH;
         ev = 1'b0;
         model_zero();
      end else begin
         if (rd) begin
            eo = mm[a];
            ev = 1'b1;
         end else begin
            ev = 1'b0;
         end
         if (ld) mm[a] = v;
      end
      e.v = ev;
      e.d = eo;
      e.b = (busy_left > 0);
      @(posedge clk);
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   // Main monitor: one expectation per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if (bus.out_valid !== e.v || bus.busy !== e.b || bus.out !== e.d) begin
               n_fail++;
               $display("FAIL main_cycle t=%0t out_valid=%b busy=%b out=%h required out_valid=%b busy=%b out=%h",
                        $time, bus.out_valid, bus.busy, bus.out, e.v, e.b, e.d);
            end
         end
      end
   end

   // Small-instance monitor: pops whenever read data is presented.
   initial begin
      logic [SW-1:0] d;
      forever begin
         @(posedge clk);
         #2;
         if (sbus.out_valid === 1'b1) begin
            n_tests++;
            if (q2.size() == 0) begin
               n_fail++;
               $display("FAIL small_unexpected_valid out=%h required no valid", sbus.out);
            end else begin
               d = q2.pop_front();
               if (sbus.out !== d) begin
                  n_fail++;
                  $display("FAIL small_read out=%h required %h", sbus.out, d);
               end
            end
         end
      end
   end

   task automatic scyc(input logic ld, input logic rd, input logic [SAB-1:0] a,
                       input logic [SW-1:0] v);
      @(negedge clk);
      sbus.load    = ld;
      sbus.read    = rd;
      sbus.address = a;
      sbus.value   = v;
      sbus.clear   = 1'b0;
      if (rd) q2.push_back(v);
   endtask

   initial begin
      int edges;
      reset = 1'b1;
      bus.load = 1'b0; bus.read = 1'b0; bus.clear = 1'b0;
      bus.address = '0; bus.value = '0;
      sreset = 1'b1;
      sbus.load = 1'b0; sbus.read = 1'b0; sbus.clear = 1'b0;
      sbus.address = '0; sbus.value = '0;
      busy_left = 0; eo = '0; ev = 1'b0;
      model_zero();

      // Reset 2 cycles, then clear with junk requests that must be ignored.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 9'd3, 16'h7777);
      for (int i = 0; i < DEPTH; i++)
         cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), AB'($urandom), W'($urandom));
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd0,   '0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd131, '0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd511, '0);
      idle(1);

      // Writes then back-to-back reads, then out holds on idle.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'd131, 16'h0003);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'd109, 16'h000F);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd131, '0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd109, '0);
      idle(2);

      // Read-first on same-address read/write.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 9'd131, 16'h00AA);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd131, '0);

      // Clear request drops a concurrent load; reads during busy ignored.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'd5, 16'hBEEF);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 9'd6, 16'h1234);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd5, '0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd5, '0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd6, '0);

      // Reset at clear step 200 restarts the full sequence.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'd40, 16'h4040);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
      idle(200);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      idle(DEPTH + 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd40, '0);

      // Reset in IDLE discards a concurrent load and read.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'd7, 16'h5555);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 9'd7, 16'h9999);
      idle(DEPTH);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd7, '0);

      // Randomized traffic over a narrow address window to force hits.
      for (int i = 0; i < 2000; i++) begin
         logic [AB-1:0] a;
         a = ($urandom_range(0, 3) == 0) ? AB'($urandom) : AB'($urandom_range(500, 511));
         cyc(($urandom_range(0, 999) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 599) == 0), a, W'($urandom));
      end
      idle(2);

      // Small instance: clear length and extreme address/data values.
      @(negedge clk);
      sreset = 1'b0;
      edges = 0;
      for (int i = 0; i < 3 * SDEPTH; i++) begin
         @(posedge clk);
         #1;
         edges++;
         if (sbus.busy !== 1'b1) break;
      end
      n_tests++;
      if (edges != SDEPTH) begin
         n_fail++;
         $display("FAIL small_clear_edges got %0d required %0d", edges, SDEPTH);
      end
      scyc(1'b1, 1'b0, 4'd15, 8'hFF);
      scyc(1'b1, 1'b0, 4'd0,  8'h01);
      scyc(1'b0, 1'b1, 4'd15, 8'hFF);
      scyc(1'b0, 1'b1, 4'd0,  8'h01);
      scyc(1'b0, 1'b0, 4'd0,  8'h00);
      repeat (3) @(posedge clk);
      #3;
      n_tests++;
      if (q2.size() != 0 || q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending main=%0d small=%0d required 0", q.size(), q2.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
